// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, timing defaults and frame constants shared by uart_recv and uart_send
package uart_pkg;
  localparam int DIV_NUM_DEF = 5208;
  localparam int WIDTH_DEF = 13;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: rx synchronizer chain with previous-value register for falling-edge detection
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall_edge
);
  logic [SYNC_STAGES-1:0] chain;
  logic prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '1;
      prev <= 1'b1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], rx};
      prev <= chain[SYNC_STAGES-1];
    end
  end
  assign rx_s = chain[SYNC_STAGES-1];
  assign fall_edge = prev & ~rx_s;
endmodule

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver with midpoint sampling, stop-bit check and one-cycle valid/error strobes
module uart_recv
  import uart_pkg::*;
#(
  parameter int DIV_NUM = DIV_NUM_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(DIV_NUM);
  localparam logic [WIDTH-1:0] HALF = WIDTH'(DIV_NUM / 2);
  state_t state, state_n;
  logic [WIDTH-1:0] timer, timer_n;
  logic [2:0] cnt, cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n, data_n;
  logic dv_n, fe_n, rx_s, fall_edge;
  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_s(rx_s),
    .fall_edge(fall_edge)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      cnt <= '0;
      shift <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      cnt <= cnt_n;
      shift <= shift_n;
      data_out <= data_n;
      data_valid <= dv_n;
      frame_err <= fe_n;
    end
  end
  // data bits and stop bit are sampled once per full period after the start-bit midpoint
  always_comb begin
    state_n = state;
    timer_n = (timer == LAST) ? '0 : timer + WIDTH'(1);
    cnt_n = cnt;
    shift_n = shift;
    data_n = data_out;
    dv_n = 1'b0;
    fe_n = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        state_n = fall_edge ? START : IDLE;
      end
      START: if (timer == HALF) begin
        timer_n = '0;
        cnt_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (timer == LAST) begin
        shift_n = {rx_s, shift[DATA_BITS-1:1]};
        cnt_n = cnt + 3'd1;
        state_n = (cnt == 3'(DATA_BITS - 1)) ? STOP : DATA;
      end
      STOP: if (timer == LAST) begin
        state_n = rx_s ? IDLE : BREAK;
        data_n = rx_s ? shift : data_out;
        dv_n = rx_s;
        fe_n = ~rx_s;
      end
      BREAK: begin
        timer_n = '0;
        state_n = rx_s ? IDLE : BREAK;
      end
      default: state_n = IDLE;
    endcase
  end
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: randomized self-checking bench for uart_recv against a frame-level reference model
module tb_uart_recv;
  localparam int DIV = 15;
  localparam int BIT = DIV + 1;
  localparam int SYNC = 2;
  localparam int LAT = SYNC + 1 + DIV / 2 + 9 * BIT + 1;
  logic clk = 1'b0;
  logic rst, rx;
  logic [7:0] data_out;
  logic data_valid, frame_err, busy;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int n_both = 0;
  int rd = 0;
  int frd = 0;
  logic [7:0] obs_q[$];
  int obs_t[$];
  logic obs_busy[$];
  logic [7:0] fe_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] expfe_q[$];
  logic [7:0] last_good = 8'h00;
  uart_recv #(.DIV_NUM(DIV), .WIDTH(4), .SYNC_STAGES(SYNC)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data_out(data_out),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      obs_q.push_back(data_out);
      obs_t.push_back(cyc);
      obs_busy.push_back(busy);
    end
    if (frame_err === 1'b1) fe_q.push_back(data_out);
    if (data_valid === 1'b1 && frame_err === 1'b1) n_both++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask
  task automatic bit_out(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  // reference model: a good stop bit yields the byte, a bad one yields an error holding the last good byte
  task automatic frame(input logic [7:0] b, input logic ok);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(ok);
    if (ok) begin
      exp_q.push_back(b);
      last_good = b;
    end else expfe_q.push_back(last_good);
  endtask
  task automatic check_sec(input string tag);
    chk({tag, "_cnt"}, obs_q.size() - rd, exp_q.size());
    for (int i = 0; i < exp_q.size() && rd + i < obs_q.size(); i++) begin
      chk({tag, "_data"}, obs_q[rd+i], exp_q[i]);
      chk({tag, "_busy"}, obs_busy[rd+i], 0);
    end
    chk({tag, "_ferr"}, fe_q.size() - frd, expfe_q.size());
    for (int i = 0; i < expfe_q.size() && frd + i < fe_q.size(); i++)
      chk({tag, "_hold"}, fe_q[frd+i], expfe_q[i]);
    rd = obs_q.size();
    frd = fe_q.size();
    exp_q.delete();
    expfe_q.delete();
  endtask
  initial begin
    int t0, base;
    logic [7:0] b;
    logic ok;
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", data_out, 8'h00);
    chk("rst_dv", data_valid, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    idle(5);
    t0 = cyc;
    base = obs_q.size();
    frame(8'hA5, 1'b1);
    idle(3 * BIT);
    if (obs_t.size() > base) chk("latency", (obs_t[base] - t0 >= LAT - 1) && (obs_t[base] - t0 <= LAT + 1), 1);
    check_sec("a5");
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    repeat (BIT) @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    frame(8'h3C, 1'b1);
    idle(3 * BIT);
    check_sec("glitch");
    frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(2 * BIT);
    frame(8'h81, 1'b1);
    idle(3 * BIT);
    check_sec("ferr");
    base = obs_q.size();
    frame(8'h00, 1'b1);
    frame(8'hFF, 1'b1);
    frame(8'h55, 1'b1);
    idle(3 * BIT);
    for (int i = 1; i < 3; i++)
      if (base + i < obs_t.size())
        chk("b2b_gap", (obs_t[base+i] - obs_t[base+i-1] >= 10 * BIT - 1) && (obs_t[base+i] - obs_t[base+i-1] <= 10 * BIT + 1), 1);
    check_sec("b2b");
    b = 8'hF0;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(b[i]);
    rx = b[4];
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_dv", data_valid, 0);
    chk("mid_rst_fe", frame_err, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (BIT - BIT / 2 - 1) @(negedge clk);
    for (int i = 5; i < 8; i++) bit_out(b[i]);
    bit_out(1'b1);
    idle(BIT);
    frame(8'h0F, 1'b1);
    idle(3 * BIT);
    check_sec("mid_rst");
    for (int i = 0; i < 256; i++) begin
      frame(8'(i), 1'b1);
      idle($urandom_range(0, 3));
    end
    idle(3 * BIT);
    check_sec("sweep");
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      frame(b, ok);
      if (!ok) begin
        rx = 1'b0;
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      idle($urandom_range(ok ? 0 : 4, 20));
    end
    idle(3 * BIT);
    check_sec("rand");
    chk("excl", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- UART receiver, 8N1 frame, LSB first. Counterpart of the team's uart_send transmitter.
- Sits between the asynchronous rx pin and the CRC datapath.
- Synchronizes rx, detects the start bit, samples each bit at its midpoint, checks the stop bit.
- Presents each received byte with a one-cycle valid strobe; bad frames raise a one-cycle error strobe instead.

Parameters:
- DIV_NUM, 5208, bit period minus one in clk cycles (bit period = DIV_NUM+1 clocks; 9600 baud at 50 MHz), identical to the transmitter's value.
- WIDTH, 13, width of the bit-timer counter; must satisfy 2^WIDTH > DIV_NUM.
- SYNC_STAGES, 2, number of rx synchronizer flops (legal values 2 or 3).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idle high.
- data_out  output  8  last correctly received byte; held until the next good frame.
- data_valid  output  1  one-cycle pulse; data_out is new in the same cycle.
- frame_err  output  1  one-cycle pulse; stop bit was sampled low.
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset values:
  - data_out=8'h00, data_valid=0, frame_err=0, busy=0.
  - Synchronizer flops = 1; state=IDLE; bit timer=0; bit counter=0.
- Synchronization: rx passes through SYNC_STAGES flops. All logic uses only the synchronized signal rx_s.
- Falling-edge detection: rx_s==0 while its previous value was 1, in state IDLE.
- Bit timer: counts 0..DIV_NUM, then wraps to 0. The midpoint is reached when timer == DIV_NUM/2 (integer division).
- States and transitions:
  - IDLE:
    - On a falling edge: go to START, clear the timer, set busy=1.
  - START:
    - At the midpoint, if rx_s==1: false start. Go to IDLE with busy=0 and no strobes.
    - At the midpoint, if rx_s==0: clear the timer, clear the bit counter, go to DATA.
  - DATA:
    - Each time the timer reaches DIV_NUM (one full bit period after the start midpoint), shift rx_s into shift[7] (right shift, LSB first) and increment the bit counter.
    - After the 8th sample, go to STOP.
  - STOP:
    - One bit period later, sample rx_s.
    - If 1: data_out <= shift and data_valid=1 on the next cycle. Go to IDLE with busy=0 in that same cycle.
    - If 0: frame_err=1 for one cycle, data_out unchanged, go to BREAK.
  - BREAK:
    - Stay until rx_s==1, then go to IDLE with busy=0. A line held low therefore produces exactly one frame_err.
- Latency: data_valid rises SYNC_STAGES + 1 + (DIV_NUM/2) + 9*(DIV_NUM+1) + 1 clocks after the rx falling edge (±1 clock of edge phase).
- Back-to-back frames: the stop bit is sampled mid-bit. A start edge arriving within the last half of the stop bit or immediately after it must be caught, so IDLE is entered in time to see it. Frame gap zero must work.
- data_valid and frame_err are never high in the same cycle. Neither is high outside the STOP→IDLE/BREAK transition cycle.
- rx changes during DATA or STOP are ignored except at sample points; no oversampling or majority vote.
- Reset mid-frame: on the next clock all state and outputs take their reset values. The partially received byte is discarded and produces no strobe.
- The busy input to the transmitter is not coupled; the blocks are independent.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants: IDLE, START, DATA, STOP, BREAK.
  - DIV_NUM/WIDTH defaults, shared with uart_send.
  - Frame length constant, DATA_BITS=8.
- Sub-module uart_rx_sync: SYNC_STAGES flop chain plus previous-value register. Outputs rx_s and fall_edge; its reset value is 1.
- The FSM, bit timer and shift register stay in uart_recv.

Test Plan:
- Byte 8'hA5, DIV_NUM=15, WIDTH=4, ideal timing (line bits 0,1,0,1,0,0,1,0,1,1) -> one data_valid pulse with data_out=8'hA5; frame_err never high; busy falls in the data_valid cycle.
- Glitch: rx low for 3 clocks, then high (DIV_NUM=15) -> no data_valid and no frame_err; busy returns to 0 at the START midpoint; the next byte 8'h3C is still received correctly.
- Framing error: byte 8'h3C with the stop bit driven 0, then rx held low 40 clocks -> exactly one frame_err pulse; no data_valid; data_out keeps its previous value; a following 8'h81 is received correctly.
- Back-to-back bytes 8'h00, 8'hFF, 8'h55 with zero idle gap -> three data_valid pulses in order, each (DIV_NUM+1)*10 clocks apart ±1.
- Reset asserted for 1 clock in the middle of bit 4 of 8'hF0 -> all outputs 0 on the next clock; no strobe for that frame; the following byte 8'h0F is received correctly.
- Loopback: uart_send tx -> uart_recv rx, both with DIV_NUM=5208, for 256 bytes 8'h00..8'hFF -> every data_out matches the sent byte; zero frame_err.
